// File: rtl/cwc_capture_core.sv
// Logic-analyser capture engine: circular sample buffer with masked/edge/forced trigger.
// Optional storage qualifier enabled by defining CWC_STORAGE_QUAL_EN (adds probe_qual port).
module cwc_capture_core #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          probe,
`ifdef CWC_STORAGE_QUAL_EN
    input  logic                       probe_qual,
`endif
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       trig_force,
    input  logic [1:0]                 trig_mode,
    input  logic [DATA_W-1:0]          trig_mask,
    input  logic [DATA_W-1:0]          trig_value,
    input  logic [$clog2(DEPTH)-1:0]   pre_trig,
    output logic                       armed,
    output logic                       triggered,
    output logic                       done,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     wp_reg, wp_next;
    logic [AW-1:0]     cnt_reg, cnt_next;
    logic [AW-1:0]     tp_reg, tp_next;
    logic [AW-1:0]     pre_reg, pre_next;
    logic [1:0]        mode_reg, mode_next;
    logic [DATA_W-1:0] mask_reg, mask_next;
    logic [DATA_W-1:0] value_reg, value_next;
    logic [DATA_W-1:0] prev_reg, prev_next;
    logic              armed_reg, triggered_reg, done_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              qual, capturing, store, wr_en, match;
    logic [DATA_W-1:0] diff_value, diff_edge;
    logic [AW-1:0]     rd_phys;

`ifdef CWC_STORAGE_QUAL_EN
    assign qual = probe_qual;
`else
    assign qual = 1'b1;
`endif

    assign capturing = (state_reg == S_PRE) || (state_reg == S_WAIT) || (state_reg == S_POST);
    assign store     = capturing && qual;
    // A cycle that aborts or resets must not leave a stray sample behind.
    assign wr_en     = store && !abort && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_cmp
            assign diff_value[gi] = (probe[gi] ^ value_reg[gi]) & mask_reg[gi];
            assign diff_edge[gi]  = (probe[gi] ^ prev_reg[gi])  & mask_reg[gi];
        end
    endgenerate

    always_comb begin
        match = 1'b0;
        case (mode_reg)
            2'd0:    match = ~|diff_value;
            2'd1:    match = |diff_value;
            2'd2:    match = |diff_edge;
            default: match = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        wp_next    = wp_reg;
        cnt_next   = cnt_reg;
        tp_next    = tp_reg;
        pre_next   = pre_reg;
        mode_next  = mode_reg;
        mask_next  = mask_reg;
        value_next = value_reg;
        prev_next  = prev_reg;
        if (abort) begin
            state_next = S_IDLE;
        end else if (arm && (state_reg == S_IDLE || state_reg == S_DONE)) begin
            mode_next  = trig_mode;
            mask_next  = trig_mask;
            value_next = trig_value;
            pre_next   = pre_trig;
            wp_next    = '0;
            cnt_next   = '0;
            prev_next  = '0;
            state_next = (pre_trig == '0) ? S_WAIT : S_PRE;
        end else if (store) begin
            wp_next   = wp_reg + AW'(1);
            prev_next = probe;
            case (state_reg)
                S_PRE: begin
                    cnt_next = cnt_reg + AW'(1);
                    if (cnt_reg + AW'(1) == pre_reg)
                        state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (match || trig_force) begin
                        tp_next = wp_reg;
                        if (pre_reg == LAST) begin
                            state_next = S_DONE;
                        end else begin
                            state_next = S_POST;
                            cnt_next   = LAST - pre_reg;
                        end
                    end
                end
                S_POST: begin
                    cnt_next = cnt_reg - AW'(1);
                    if (cnt_reg == AW'(1))
                        state_next = S_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            wp_reg        <= '0;
            cnt_reg       <= '0;
            tp_reg        <= '0;
            pre_reg       <= '0;
            mode_reg      <= '0;
            mask_reg      <= '0;
            value_reg     <= '0;
            prev_reg      <= '0;
            armed_reg     <= 1'b0;
            triggered_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wp_reg        <= wp_next;
            cnt_reg       <= cnt_next;
            tp_reg        <= tp_next;
            pre_reg       <= pre_next;
            mode_reg      <= mode_next;
            mask_reg      <= mask_next;
            value_reg     <= value_next;
            prev_reg      <= prev_next;
            armed_reg     <= (state_next == S_PRE) || (state_next == S_WAIT);
            triggered_reg <= (state_next == S_POST);
            done_reg      <= (state_next == S_DONE);
        end
    end

    // Logical index 0 is the oldest sample, pre_trig samples before the trigger.
    assign rd_phys = (tp_reg - pre_reg) + rd_addr;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wp_reg] <= probe;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data_reg <= '0;
        else
            rd_data_reg <= mem[rd_phys];
    end

    assign armed     = armed_reg;
    assign triggered = triggered_reg;
    assign done      = done_reg;
    assign rd_data   = rd_data_reg;
endmodule

// File: tb/tb_cwc_capture_core.sv
// Bench for cwc_capture_core (DEPTH=16, DATA_W=8): directed table, hand sequences, random vs model.
module tb_cwc_capture_core;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int MAXC   = 300;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] probe = '0;
    logic              probe_qual = 1'b0;
    logic              arm = 1'b0, abort = 1'b0, trig_force = 1'b0;
    logic [1:0]        trig_mode = '0;
    logic [DATA_W-1:0] trig_mask = '0, trig_value = '0;
    logic [AW-1:0]     pre_trig = '0, rd_addr = '0;
    logic              armed, triggered, done;
    logic [DATA_W-1:0] rd_data;

    cwc_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .probe(probe),
`ifdef CWC_STORAGE_QUAL_EN
        .probe_qual(probe_qual),
`endif
        .arm(arm), .abort(abort), .trig_force(trig_force),
        .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
        .pre_trig(pre_trig), .armed(armed), .triggered(triggered), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] stim [MAXC];
    bit         qv [MAXC];
    bit         fv [MAXC];
    bit         av [MAXC];
    logic [7:0] got_buf [DEPTH];
    logic [7:0] exp_buf [DEPTH];
    int         m_last, m_trig;
    bit         m_ok;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] mask;
        logic [7:0] value;
        logic [3:0] pre;
        int         pat;
        int         force_at;
        bit         qual_alt;
        int         exp_split;
        logic [7:0] exp_lo;
        logic [7:0] exp_base;
        logic [7:0] exp_step;
        int         exp_last;
        int         exp_trig;
    } vec_t;
    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit qual_on(input int j);
`ifdef CWC_STORAGE_QUAL_EN
        return qv[j];
`else
        return 1'b1;
`endif
    endfunction

    // Reference: list every stored sample, find the trigger, take DEPTH samples from trigger-pre.
    function automatic void model(input logic [1:0] mode, input logic [7:0] mask,
                                  input logic [7:0] value, input int pre);
        logic [7:0] s[$];
        logic [7:0] prev;
        int k, tc, n;
        bit hit;
        prev = 8'h00;
        k = -1;
        tc = -1;
        m_ok = 1'b0;
        for (int j = 0; j < MAXC; j++) begin
            if (qual_on(j)) begin
                s.push_back(stim[j]);
                n = s.size() - 1;
                if (k < 0 && n >= pre) begin
                    case (mode)
                        2'd0:    hit = ((stim[j] ^ value) & mask) == 8'h00;
                        2'd1:    hit = ((stim[j] ^ value) & mask) != 8'h00;
                        2'd2:    hit = ((stim[j] ^ prev) & mask) != 8'h00;
                        default: hit = 1'b0;
                    endcase
                    if (hit || fv[j]) begin
                        k = n;
                        tc = j;
                    end
                end
                prev = stim[j];
                if (k >= 0 && n == k + DEPTH - pre - 1) begin
                    m_ok = 1'b1;
                    m_last = j;
                    m_trig = j - tc;
                    for (int i = 0; i < DEPTH; i++) exp_buf[i] = s[k - pre + i];
                    break;
                end
            end
        end
    endfunction

    task automatic fill_stim(input int pat, input int force_at, input bit qual_alt);
        for (int j = 0; j < MAXC; j++) begin
            if (pat == 0) stim[j] = 8'(j);
            else          stim[j] = (j < 40) ? 8'h00 : 8'h80;
            fv[j] = (j == force_at);
            qv[j] = qual_alt ? (j % 2 == 0) : 1'b1;
            av[j] = 1'b0;
        end
    endtask

    // Arms with the given config, then drives junk config so only latched values matter.
    task automatic run_capture(input logic [1:0] mode, input logic [7:0] mask, input logic [7:0] value,
                               input logic [3:0] pre, output int last_cyc, output int trig_cnt,
                               output bit got_done);
        trig_mode = mode; trig_mask = mask; trig_value = value; pre_trig = pre; arm = 1'b1;
        step();
        arm = 1'b0; trig_mode = 2'd0; trig_mask = 8'hFF; trig_value = stim[5]; pre_trig = '0;
        got_done = 1'b0; trig_cnt = 0; last_cyc = -1;
        for (int j = 0; j < MAXC; j++) begin
            probe = stim[j]; probe_qual = qv[j]; trig_force = fv[j]; arm = av[j];
            step();
            if (triggered) trig_cnt++;
            if (done) begin
                got_done = 1'b1;
                last_cyc = j;
                break;
            end
        end
        arm = 1'b0; trig_force = 1'b0; probe_qual = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            step();
            got_buf[i] = rd_data;
        end
    endtask

    task automatic run_entry(input int t, input vec_t v);
        int lc, tcnt;
        bit gd;
        logic [7:0] e;
        fill_stim(v.pat, v.force_at, v.qual_alt);
        run_capture(v.mode, v.mask, v.value, v.pre, lc, tcnt, gd);
        check($sformatf("v%0d done", t), 32'(gd), 32'd1);
        check($sformatf("v%0d done_cycle", t), lc, v.exp_last);
        check($sformatf("v%0d trig_cycles", t), tcnt, v.exp_trig);
        read_all();
        for (int i = 0; i < DEPTH; i++) begin
            e = (i < v.exp_split) ? v.exp_lo : v.exp_base + 8'(int'(v.exp_step) * i);
            check($sformatf("v%0d rd[%0d]", t, i), 32'(got_buf[i]), 32'(e));
        end
    endtask

    initial begin
        int lc, tcnt;
        bit gd;
        logic [1:0] rmode;
        logic [7:0] rmask, rval;
        logic [3:0] rpre;

        tv.push_back('{2'd0, 8'hFF, 8'h20, 4'd4,  0, -1, 1'b0, 0, 8'h00, 8'h1C, 8'h01, 43, 11});
        tv.push_back('{2'd0, 8'hFF, 8'h05, 4'd0,  0, -1, 1'b0, 0, 8'h00, 8'h05, 8'h01, 20, 15});
        tv.push_back('{2'd2, 8'h80, 8'h00, 4'd8,  1, -1, 1'b0, 8, 8'h00, 8'h80, 8'h00, 47, 7});
        tv.push_back('{2'd3, 8'hFF, 8'h00, 4'd15, 0, 30, 1'b0, 0, 8'h00, 8'h0F, 8'h01, 30, 0});
`ifdef CWC_STORAGE_QUAL_EN
        tv.push_back('{2'd0, 8'hFF, 8'h20, 4'd4,  0, -1, 1'b1, 0, 8'h00, 8'h18, 8'h02, 54, 22});
`endif

        rst = 1'b1;
        repeat (3) step();
        check("reset armed", 32'(armed), 32'd0);
        check("reset triggered", 32'(triggered), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        step();

        foreach (tv[t]) run_entry(t, tv[t]);

        // Abort while post-trigger filling, then re-arm.
        fill_stim(0, -1, 1'b0);
        trig_mode = 2'd0; trig_mask = 8'hFF; trig_value = 8'h05; pre_trig = '0; arm = 1'b1;
        step();
        arm = 1'b0;
        for (int j = 0; j < 40; j++) begin
            probe = stim[j];
            step();
            if (triggered) break;
        end
        check("abort pre triggered", 32'(triggered), 32'd1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort armed", 32'(armed), 32'd0);
        check("abort triggered", 32'(triggered), 32'd0);
        check("abort done", 32'(done), 32'd0);
        repeat (3) step();
        check("abort stays idle", 32'({armed, triggered, done}), 32'd0);
        run_entry(10, tv[0]);

        // Reset during WAIT.
        fill_stim(0, -1, 1'b0);
        trig_mode = 2'd3; trig_mask = 8'hFF; pre_trig = 4'd2; arm = 1'b1;
        step();
        arm = 1'b0;
        for (int j = 0; j < 6; j++) begin
            probe = stim[j];
            step();
        end
        check("wait armed", 32'(armed), 32'd1);
        rst = 1'b1;
        step();
        check("rst armed", 32'(armed), 32'd0);
        check("rst triggered", 32'(triggered), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;
        repeat (2) step();
        check("rst stays idle", 32'({armed, triggered, done}), 32'd0);

        // Second arm pulse during PRE must be ignored.
        fill_stim(0, 20, 1'b0);
        av[2] = 1'b1;
        run_capture(2'd3, 8'hFF, 8'h00, 4'd8, lc, tcnt, gd);
        check("armpre done", 32'(gd), 32'd1);
        check("armpre done_cycle", lc, 27);
        read_all();
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("armpre rd[%0d]", i), 32'(got_buf[i]), 32'(12 + i));

        // abort wins over a simultaneous arm in DONE.
        arm = 1'b1; abort = 1'b1; pre_trig = 4'd3;
        step();
        arm = 1'b0; abort = 1'b0;
        check("abort+arm armed", 32'(armed), 32'd0);
        check("abort+arm done", 32'(done), 32'd0);

        // Random captures against the reference model.
        for (int r = 0; r < 10; r++) begin
            rmode = 2'($urandom_range(0, 3));
            rmask = 8'($urandom);
            rval  = 8'($urandom_range(0, 3));
            rpre  = 4'($urandom_range(0, 15));
            for (int j = 0; j < MAXC; j++) begin
                stim[j] = 8'($urandom_range(0, 3));
                fv[j]   = ($urandom_range(0, 9) == 0);
                qv[j]   = ($urandom_range(0, 1) == 1);
                av[j]   = 1'b0;
            end
            model(rmode, rmask, rval, int'(rpre));
            run_capture(rmode, rmask, rval, rpre, lc, tcnt, gd);
            check($sformatf("rnd%0d done", r), 32'(gd), 32'(m_ok));
            if (m_ok && gd) begin
                check($sformatf("rnd%0d done_cycle", r), lc, m_last);
                check($sformatf("rnd%0d trig_cycles", r), tcnt, m_trig);
                read_all();
                for (int i = 0; i < DEPTH; i++)
                    check($sformatf("rnd%0d rd[%0d]", r, i), 32'(got_buf[i]), 32'(exp_buf[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
